global_avg_pool: RTL and testbench

- Streaming global average pooling stage directly downstream of the final Inception-ResNet-C stage (plus closing 1x1 conv) in the Inception-ResNet-v2 datapath.
- Consumes an 8x8xC feature map serially, channel-major: all WIDTH*WIDTH pixels of channel 0 in raster order, then channel 1, and so on.
- Emits one averaged value per channel, giving the 1x1xC vector that feeds the dropout/fully-connected stage.
- Same valid-only streaming handshake as the other layer blocks; no backpressure.

---
 rtl/global_avg_pool.sv | 101 ++++++++++
 tb/tb_global_avg_pool.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/global_avg_pool.sv
// Streaming global average pool: sums WIDTH*WIDTH pixels per channel and emits a round-half-up mean.
// Latency 1 cycle after a channel's last pixel; valid-only input, no backpressure.
module global_avg_pool #(
   parameter int WIDTH      = 8,
   parameter int DATA_WIDTH = 32,
   parameter int CHANNELS   = 1536,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   output logic [CH_W-1:0]       ch_out,
   output logic                  last_out
);

   localparam int P     = WIDTH * WIDTH;
   localparam int S     = $clog2(P);
   localparam int ACC_W = DATA_WIDTH + S;

   localparam logic [S-1:0]     PIX_LAST = S'(P - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
   localparam logic [ACC_W-1:0] HALF     = ACC_W'(1) << (S - 1);

   typedef enum logic {ACCUM, FINISH} state_t;

   logic signed [ACC_W-1:0] r_acc;
   logic        [S-1:0]     r_pix_cnt;
   logic        [CH_W-1:0]  r_ch_cnt;
   logic [DATA_WIDTH-1:0]   r_pxl_out;
   logic                    r_valid_out;
   logic [CH_W-1:0]         r_ch_out;
   logic                    r_last_out;

   state_t                  w_state;
   logic signed [ACC_W-1:0] w_pxl_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_rnd;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic        [S-1:0]     w_pix_nxt;
   logic        [CH_W-1:0]  w_ch_nxt;
   logic                    w_done;

   // Sum of P pixels needs only S extra bits, and adding half an LSB cannot carry out of ACC_W.
   assign w_pxl_ext = {{S{pxl_in[DATA_WIDTH-1]}}, pxl_in};
   assign w_sum     = r_acc + w_pxl_ext;
   assign w_rnd     = w_sum + $signed(HALF);

   always_comb begin
      w_state   = (r_pix_cnt == PIX_LAST) ? FINISH : ACCUM;
      w_acc_nxt = r_acc;
      w_pix_nxt = r_pix_cnt;
      w_ch_nxt  = r_ch_cnt;
      w_done    = 1'b0;
      if (valid_in) begin
         case (w_state)
            ACCUM: begin
               w_pix_nxt = r_pix_cnt + 1'b1;
               // First pixel loads so consecutive channels need no clear cycle.
               w_acc_nxt = (r_pix_cnt == '0) ? w_pxl_ext : w_sum;
            end
            FINISH: begin
               w_pix_nxt = '0;
               w_ch_nxt  = (r_ch_cnt == CH_LAST) ? '0 : r_ch_cnt + 1'b1;
               w_done    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc       <= '0;
         r_pix_cnt   <= '0;
         r_ch_cnt    <= '0;
         r_pxl_out   <= '0;
         r_valid_out <= 1'b0;
         r_ch_out    <= '0;
         r_last_out  <= 1'b0;
      end else begin
         r_acc       <= w_acc_nxt;
         r_pix_cnt   <= w_pix_nxt;
         r_ch_cnt    <= w_ch_nxt;
         r_valid_out <= w_done;
         r_last_out  <= w_done && (r_ch_cnt == CH_LAST);
         if (w_done) begin
            r_pxl_out <= DATA_WIDTH'(w_rnd >>> S);
            r_ch_out  <= r_ch_cnt;
         end
      end
   end

   assign pxl_out   = r_pxl_out;
   assign valid_out = r_valid_out;
   assign ch_out    = r_ch_out;
   assign last_out  = r_last_out;

endmodule

// File: tb/tb_global_avg_pool.sv
// Directed table-driven bench for global_avg_pool (8x8 map, 32-bit pixels, 3 channels).
module tb_global_avg_pool;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] pxl_in;
   logic [31:0] pxl_out;
   logic        valid_out;
   logic [1:0]  ch_out;
   logic        last_out;

   global_avg_pool #(.WIDTH(8), .DATA_WIDTH(32), .CHANNELS(3)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
      .pxl_out(pxl_out), .valid_out(valid_out), .ch_out(ch_out), .last_out(last_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          mode;     // 0 const a, 1 ramp i, 2 ramp -i, 3 pixel0=a rest 0
      logic [31:0] a;
      int          gmax;     // max idle cycles inserted before each pixel
      logic [31:0] exp_pxl;
      logic [1:0]  exp_ch;
      logic        exp_last;
   } vec_t;

   vec_t vecs[12];

   int errors = 0;
   int checks = 0;
   int spurious = 0;
   int pulse_cnt = 0;

   logic        pend = 1'b0;
   logic [31:0] pend_pxl;
   logic [1:0]  pend_ch;
   logic        pend_last;

   always @(negedge clk) if (valid_out === 1'b1) pulse_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: verify outputs produced by the previous cycle, then drive this cycle's input.
   task automatic cycle(input logic v, input logic [31:0] d, input logic fin,
                        input logic [31:0] ep, input logic [1:0] ec, input logic el);
      @(negedge clk);
      if (pend) begin
         check("valid_out_pulse", 64'(valid_out), 64'd1);
         check("pxl_out", 64'(pxl_out), 64'(pend_pxl));
         check("ch_out", 64'(ch_out), 64'(pend_ch));
         check("last_out", 64'(last_out), 64'(pend_last));
      end else if (valid_out !== 1'b0 || last_out !== 1'b0) begin
         spurious++;
      end
      pend      = v && fin;
      pend_pxl  = ep;
      pend_ch   = ec;
      pend_last = el;
      valid_in  = v;
      pxl_in    = d;
   endtask

   task automatic send_channel(input int mode, input logic [31:0] a, input int gmax,
                               input logic [31:0] ep, input logic [1:0] ec, input logic el);
      logic [31:0] val;
      for (int i = 0; i < 64; i++) begin
         if (gmax > 0) repeat ($urandom_range(0, gmax)) cycle(1'b0, 32'h0, 1'b0, ep, ec, el);
         case (mode)
            1:       val = 32'(i);
            2:       val = 32'(-i);
            3:       val = (i == 0) ? a : 32'h0;
            default: val = a;
         endcase
         cycle(1'b1, val, i == 63, ep, ec, el);
      end
   endtask

   initial begin
      vecs[0]  = '{0, 32'd5,        0, 32'd5,        2'd0, 1'b0};
      vecs[1]  = '{0, 32'd5,        0, 32'd5,        2'd1, 1'b0};
      vecs[2]  = '{1, 32'd0,        0, 32'd32,       2'd2, 1'b1};
      vecs[3]  = '{3, -32'sd32,     0, 32'd0,        2'd0, 1'b0};
      vecs[4]  = '{3, -32'sd33,     0, 32'hFFFFFFFF, 2'd1, 1'b0};
      vecs[5]  = '{0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 2'd2, 1'b1};
      vecs[6]  = '{0, 32'h80000000, 0, 32'h80000000, 2'd0, 1'b0};
      vecs[7]  = '{0, 32'd5,        5, 32'd5,        2'd1, 1'b0};
      vecs[8]  = '{0, 32'd5,        5, 32'd5,        2'd2, 1'b1};
      vecs[9]  = '{0, -32'sd3,      0, 32'hFFFFFFFD, 2'd0, 1'b0};
      vecs[10] = '{2, 32'd0,        0, 32'hFFFFFFE1, 2'd1, 1'b0};
      vecs[11] = '{0, 32'd1,        0, 32'd1,        2'd2, 1'b1};

      reset    = 1'b1;
      valid_in = 1'b0;
      pxl_in   = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_pxl_out", 64'(pxl_out), 64'd0);
      check("reset_valid_out", 64'(valid_out), 64'd0);
      check("reset_ch_out", 64'(ch_out), 64'd0);
      check("reset_last_out", 64'(last_out), 64'd0);
      reset = 1'b0;

      for (int k = 0; k < 12; k++) begin
         send_channel(vecs[k].mode, vecs[k].a, vecs[k].gmax,
                      vecs[k].exp_pxl, vecs[k].exp_ch, vecs[k].exp_last);
         check("no_extra_pulse", 64'(spurious), 64'd0);
      end
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0);
      check("hold_pxl_out", 64'(pxl_out), 64'd1);
      check("hold_ch_out", 64'(ch_out), 64'd2);
      check("idle_valid_out", 64'(valid_out), 64'd0);

      // Abort channel 2 after 40 pixels with an asynchronous reset.
      send_channel(0, 32'd3, 0, 32'd3, 2'd0, 1'b0);
      send_channel(0, 32'd4, 0, 32'd4, 2'd1, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b1, 32'd9, 1'b0, 32'h0, 2'd0, 1'b0);
      @(negedge clk);
      check("pre_reset_pxl_out", 64'(pxl_out), 64'd4);
      check("pre_reset_ch_out", 64'(ch_out), 64'd1);
      valid_in = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_reset_pxl_out", 64'(pxl_out), 64'd0);
      check("async_reset_ch_out", 64'(ch_out), 64'd0);
      check("async_reset_valid_out", 64'(valid_out), 64'd0);
      check("async_reset_last_out", 64'(last_out), 64'd0);
      pend = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send_channel(0, 32'd7, 0, 32'd7, 2'd0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0);
      repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0);
      check("no_extra_pulse_end", 64'(spurious), 64'd0);
      check("total_pulses", 64'(pulse_cnt), 64'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
